// File: rtl/fetch_queue.sv
// Instruction prefetch queue: issues in-order fetches ahead of decode, buffers returned
// instructions with their PCs, and flushes/discards in-flight work on a redirect.
module fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     jump,
    input  logic [XLEN-1:0]          jump_addr,
    output logic                     imem_req,
    output logic [XLEN-1:0]          imem_addr,
    input  logic                     imem_ready,
    input  logic                     imem_rvalid,
    input  logic [XLEN-1:0]          imem_rdata,
    output logic                     inst_valid,
    output logic [XLEN-1:0]          inst,
    output logic [XLEN-1:0]          inst_addr,
    input  logic                     inst_ready,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } entry_t;

    entry_t          entries [DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   outstanding, drop;
    logic [XLEN-1:0] fpc, rpc;
    logic [CW:0]     inflight;
    logic [XLEN-1:0] target;
    logic            xfer, discard, push, pop;

    // Buffered plus in-flight entries form the credit pool, so the queue can never overflow.
    assign inflight   = {1'b0, count} + {1'b0, outstanding};
    assign imem_req   = ~rst & ~jump & (inflight < (CW+1)'(DEPTH));
    assign imem_addr  = fpc;
    assign target     = jump_addr & ~XLEN'(3);

    assign xfer       = imem_req & imem_ready;
    assign discard    = drop != '0;
    assign push       = imem_rvalid & ~jump & ~discard;
    assign pop        = inst_valid & inst_ready & ~jump;

    assign inst_valid = count != '0;
    assign inst       = entries[rd_ptr].inst;
    assign inst_addr  = entries[rd_ptr].pc;

    always_ff @(posedge clk) begin
        if (push)
            entries[wr_ptr] <= '{inst: imem_rdata, pc: rpc};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fpc         <= RESET_PC;
            rpc         <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            outstanding <= outstanding + CW'(xfer) - CW'(imem_rvalid);
            if (jump) begin
                // Everything still in flight belongs to the old stream; a response landing now is dropped too.
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
                fpc    <= target;
                rpc    <= target;
                drop   <= outstanding - CW'(imem_rvalid);
            end else begin
                if (xfer)
                    fpc <= fpc + XLEN'(4);
                if (imem_rvalid && discard)
                    drop <= drop - CW'(1);
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                    rpc    <= rpc + XLEN'(4);
                end
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end
endmodule
